round_sequencer: RTL and testbench

Parametrised AES round sequencer for the encryption datapath, replacing the fixed 16-step round counter. It supports AES-128, AES-192 and AES-256 round counts, plus a programmable custom limit. It adds a start/busy/done handshake, stall, abort and first/last-round flags. It sits between the USB packet controller, which issues start and abort, and the cipher/key-expansion datapath, which consumes round_count, first_round, last_round and count_enable.

---
 rtl/round_sequencer.sv | 87 ++++++++
 tb/tb_round_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// round_sequencer: AES round counter with start/busy/done handshake, stall, abort and first/last flags
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   start, abort        run request (IDLE/DONE only) and synchronous cancel (highest priority)
//   mode, round_limit   round-count select (10/12/14/custom) and custom limit, latched on start
//   count_enable        datapath ready; counter stalls while low
//   round_count         current round 0..limit_q
//   first_round         busy and round 0
//   last_round          busy and round == limit_q
//   busy, done          RUN state, one-cycle completion pulse
//   limit_q             latched effective limit
module round_sequencer #(
    parameter int CNT_WIDTH  = 5,
    parameter int MAX_ROUNDS = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [CNT_WIDTH-1:0] round_limit,
    input  logic                 count_enable,
    input  logic                 abort,
    output logic [CNT_WIDTH-1:0] round_count,
    output logic                 first_round,
    output logic                 last_round,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] limit_q
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CNT_WIDTH-1:0] MAX_L = CNT_WIDTH'(MAX_ROUNDS);
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d, limit_d, eff_limit;
    // Custom limit is clamped to 1..MAX_ROUNDS so a run always has at least one round
    assign eff_limit = mode == 2'b00 ? CNT_WIDTH'(10) :
                       mode == 2'b01 ? CNT_WIDTH'(12) :
                       mode == 2'b10 ? CNT_WIDTH'(14) :
                       round_limit == '0 ? CNT_WIDTH'(1) :
                       round_limit > MAX_L ? MAX_L : round_limit;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = start ? RUN : IDLE;
                    count_d = '0;
                    limit_d = start ? eff_limit : limit_q;
                end
                RUN: begin
                    // Count holds at the limit while DONE is shown
                    if (count_enable) begin
                        state_d = count_q == limit_q ? DONE : RUN;
                        count_d = count_q == limit_q ? count_q : count_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
        end
    end
    assign round_count = count_q;
    assign busy        = state_q == RUN;
    assign done        = state_q == DONE;
    assign first_round = busy && count_q == '0;
    assign last_round  = busy && count_q == limit_q;
    assert property (@(posedge clk) disable iff (!n_rst) count_q <= limit_q);
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: vector table, directed corner sequences and random run against a reference model
module tb_round_sequencer;
    localparam int CW = 5;
    localparam int MR = 16;
    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [CW-1:0] round_limit = '0;
    logic          count_enable = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] round_count, limit_q;
    logic          first_round, last_round, busy, done;
    int checks = 0;
    int errors = 0;
    int m_busy = 0, m_done = 0, m_cnt = 0, m_lim = 0;
    round_sequencer #(.CNT_WIDTH(CW), .MAX_ROUNDS(MR)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .mode(mode), .round_limit(round_limit),
        .count_enable(count_enable), .abort(abort), .round_count(round_count),
        .first_round(first_round), .last_round(last_round), .busy(busy), .done(done),
        .limit_q(limit_q)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic s; logic [1:0] md; int rl; logic ce; logic ab;
        int eb; int ed; int ef; int el; int ec; int elim;
    } vec_t;
    vec_t tv[11];
    function automatic int eff(input int md, input int rl);
        if (md == 0) return 10;
        if (md == 1) return 12;
        if (md == 2) return 14;
        return rl < 1 ? 1 : (rl > MR ? MR : rl);
    endfunction
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic compare_model();
        check("model_cnt", int'(round_count), m_cnt);
        check("model_busy", int'(busy), m_busy);
        check("model_done", int'(done), m_done);
        check("model_first", int'(first_round), int'(m_busy != 0 && m_cnt == 0));
        check("model_last", int'(last_round), int'(m_busy != 0 && m_cnt == m_lim));
        check("model_limit", int'(limit_q), m_lim);
    endtask
    task automatic model_reset();
        m_busy = 0; m_done = 0; m_cnt = 0; m_lim = 0;
    endtask
    task automatic cyc(input logic s, input logic [1:0] md, input int rl, input logic ce, input logic ab);
        start = s; mode = md; round_limit = CW'(rl); count_enable = ce; abort = ab;
        @(posedge clk);
        if (ab) begin
            m_busy = 0; m_done = 0; m_cnt = 0;
        end else if (m_busy != 0) begin
            if (ce) begin
                if (m_cnt == m_lim) begin m_busy = 0; m_done = 1; end
                else m_cnt++;
            end
        end else begin
            m_done = 0;
            m_cnt = 0;
            if (s) begin m_busy = 1; m_lim = eff(int'(md), rl); end
        end
        #1;
        compare_model();
    endtask
    task automatic run_stall(input logic [1:0] md, input int lim);
        int n;
        int seen_last;
        logic ce;
        seen_last = -1;
        cyc(1, md, 0, 1, 0);
        for (n = 1; n <= 60; n++) begin
            ce = (n <= 4) ? logic'(n % 2) : 1'b1;
            cyc(0, md, 0, ce, 0);
            if (last_round) seen_last = int'(round_count);
            if (done) break;
        end
        check("stall_done_edge", n, lim + 3);
        check("stall_last_cnt", seen_last, lim);
        cyc(0, 0, 0, 1, 0);
    endtask
    initial begin
        tv[0]  = '{1, 3, 0, 1, 0,   1, 0, 1, 0, 0, 1};
        tv[1]  = '{0, 3, 0, 1, 0,   1, 0, 0, 1, 1, 1};
        tv[2]  = '{0, 3, 0, 1, 0,   0, 1, 0, 0, 1, 1};
        tv[3]  = '{0, 3, 0, 1, 0,   0, 0, 0, 0, 0, 1};
        tv[4]  = '{1, 0, 0, 1, 1,   0, 0, 0, 0, 0, 1};
        tv[5]  = '{1, 3, 31, 1, 0,  1, 0, 1, 0, 0, 16};
        tv[6]  = '{1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 16};
        tv[7]  = '{0, 0, 0, 1, 1,   0, 0, 0, 0, 0, 16};
        tv[8]  = '{1, 3, 5, 1, 0,   1, 0, 1, 0, 0, 5};
        tv[9]  = '{0, 3, 5, 1, 0,   1, 0, 0, 0, 1, 5};
        tv[10] = '{0, 3, 5, 1, 1,   0, 0, 0, 0, 0, 5};
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", int'({busy, done, first_round, last_round, round_count, limit_q}), 0);
        n_rst = 1'b1;
        model_reset();
        repeat (5) cyc(0, 0, 0, 0, 0);
        check("idle_cnt", int'(round_count), 0);
        cyc(1, 0, 0, 1, 0);
        check("aes128_first", int'(first_round), 1);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 1, 0);
            check("aes128_cnt", int'(round_count), k);
            check("aes128_last", int'(last_round), int'(k == 10));
            check("aes128_first_low", int'(first_round), 0);
        end
        cyc(0, 0, 0, 1, 0);
        check("aes128_done", int'({busy, done}), 1);
        cyc(0, 0, 0, 1, 0);
        check("aes128_idle", int'({busy, done, round_count}), 0);
        run_stall(2'b01, 12);
        run_stall(2'b10, 14);
        for (int i = 0; i < 11; i++) begin
            cyc(tv[i].s, tv[i].md, tv[i].rl, tv[i].ce, tv[i].ab);
            check($sformatf("vec%0d_flags", i), int'({busy, done, first_round, last_round}),
                  (tv[i].eb << 3) | (tv[i].ed << 2) | (tv[i].ef << 1) | tv[i].el);
            check($sformatf("vec%0d_cnt", i), int'(round_count), tv[i].ec);
            check($sformatf("vec%0d_limit", i), int'(limit_q), tv[i].elim);
        end
        cyc(1, 0, 0, 1, 0);
        repeat (6) cyc(0, 0, 0, 1, 0);
        check("abort_pre_cnt", int'(round_count), 6);
        cyc(0, 0, 0, 1, 1);
        check("abort_idle", int'({busy, round_count}), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 1, 0);
            check("abort_no_done", int'(done), 0);
        end
        repeat (3) cyc(1, 3, 2, 1, 0);
        cyc(1, 3, 2, 1, 0);
        check("b2b_done", int'({done, round_count}), 32 + 2);
        cyc(1, 3, 2, 1, 0);
        check("b2b_restart", int'({busy, first_round, round_count}), 3 << CW);
        cyc(0, 3, 2, 0, 0);
        cyc(0, 3, 2, 0, 1);
        cyc(1, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("async_reset", int'({busy, done, first_round, last_round, round_count, limit_q}), 0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_hold", int'({busy, done, round_count, limit_q}), 0);
        n_rst = 1'b1;
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 3000; i++)
            cyc(logic'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 29) == 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
